apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  Initiator end of the peripheral APB: converts the core-side req/gnt/rvalid data
//  port into APB SETUP/ACCESS transfers that drive the peripheral node's slave port.
//  Handles one transfer at a time, registers the response and returns it as a
//  single-cycle rvalid pulse. Sits between the AXI/LSU-side adapter and the APB node.
// PARAMETERS
//  APB_ADDR_WIDTH  32   APB address width (also core-side addr width)
//  APB_DATA_WIDTH  32   data width; must be 32 (pstrb_o is 4 bits)
//  TIMEOUT_CYCLES  256  ACCESS-phase cycles before abort (APB_TIMEOUT_EN only)
// PORTS
//  clk_i      in   1   clock
//  rst_i      in   1   reset, synchronous, active-high
//  req_i      in   1   core request
//  addr_i     in   AW  byte address
//  we_i       in   1   1=write 0=read
//  be_i       in   4   byte enables
//  wdata_i    in   DW  write data
//  gnt_o      out  1   request accepted this cycle
//  rvalid_o   out  1   response valid (1-cycle pulse)
//  rdata_o    out  DW  read data; held until next response
//  err_o      out  1   response error, qualified by rvalid_o
//  paddr_o    out  AW  APB address, word aligned {addr_i[AW-1:2],2'b00}
//  pwdata_o   out  DW  APB write data
//  pwrite_o   out  1   APB direction
//  pstrb_o    out  4   APB4 strobes (=be_i on writes, 4'h0 on reads)
//  psel_o     out  1   APB select
//  penable_o  out  1   APB enable
//  prdata_i   in   DW  APB read data
//  pready_i   in   1   APB ready
//  pslverr_i  in   1   APB slave error
// BEHAVIOUR
//  - Reset (rst_i=1 at a clk_i edge): state=IDLE; psel_o, penable_o, rvalid_o,
//    err_o = 0; rdata_o, paddr_o, pwdata_o, pstrb_o = 0; pwrite_o = 0.
//  - FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//    IDLE:   gnt_o = req_i (combinational, only in IDLE); on req_i latch addr/we/
//            be/wdata into APB output regs, go SETUP.
//    SETUP:  psel_o=1, penable_o=0; unconditionally go ACCESS.
//    ACCESS: psel_o=1, penable_o=1; hold until pready_i=1, then capture
//            rdata (prdata_i on reads, 0 on writes) and err = pslverr_i, go RESP.
//    RESP:   psel_o=penable_o=0; rvalid_o=1 for exactly one cycle; go IDLE.
//  - gnt_o=0 in SETUP/ACCESS/RESP; a request held during a transfer is granted in
//    the first IDLE cycle (back-to-back: one IDLE cycle between transfers).
//  - Latency with zero-wait slave: gnt at cycle N, SETUP N+1, ACCESS N+2,
//    rvalid_o at N+3. Each wait state (pready_i=0) adds one cycle.
//  - APB outputs are stable from SETUP through the last ACCESS cycle.
//  - pready_i/pslverr_i/prdata_i are ignored outside ACCESS.
//  - addr_i[1:0] are dropped; no misalignment error is raised.
//  - Reset mid-transfer: transfer is abandoned, psel_o/penable_o drop in the
//    cycle after the reset edge, no rvalid_o is issued for it.
// CONFIGURATION
//  APB_TIMEOUT_EN defined: 9-bit counter cleared on entering ACCESS, incremented
//    each ACCESS cycle with pready_i=0; on reaching TIMEOUT_CYCLES the transfer is
//    aborted -> RESP with err_o=1, rdata_o=32'hDEAD_BEEF. pready_i in the same
//    cycle as expiry wins (normal completion).
//  APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for pready_i.
// TESTING
//  1 Read, zero-wait: req addr=0x1A10_0004 we=0, prdata=0x1234_5678 -> gnt cyc0,
//    psel cyc1, penable cyc2, rvalid cyc3 rdata=0x1234_5678 err=0.
//  2 Write, 3 wait states: addr=0x1A10_1003 be=4'h3 wdata=0xCAFE_F00D -> paddr
//    0x1A10_1000, pstrb 4'h3, outputs stable 4 ACCESS cycles, rvalid cyc6 err=0.
//  3 Slave error: read with pslverr_i=1 at pready -> rvalid with err_o=1.
//  4 Back-to-back: req held high for 2 reads -> second gnt exactly 1 cycle after
//    first rvalid; no overlap of psel phases.
//  5 Reset in ACCESS (pready_i=0): rst_i for 1 cycle -> psel/penable low, no
//    rvalid, next request completes normally.
//  6 APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready_i stuck 0 -> rvalid after 16 ACCESS
//    cycles, err_o=1, rdata_o=0xDEAD_BEEF; undefined macro -> no rvalid in 1000 cycles.

Source files
------------

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   Initiator end of a peripheral APB. Turns a core-side req/gnt/rvalid data
//   port into APB SETUP/ACCESS transfers, one transfer at a time. The response
//   is registered and returned as a single-cycle rvalid pulse.
//
// Optional feature (macro APB_TIMEOUT_EN):
//   When defined, an ACCESS phase with no pready_i for TIMEOUT_CYCLES cycles is
//   aborted and answered with err_o=1, rdata_o=32'hDEAD_BEEF. When undefined,
//   ACCESS waits indefinitely for pready_i.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_i, addr_i, we_i,    core request: byte address, direction (1=write),
//   be_i, wdata_i           byte enables, write data
//   gnt_o                   request accepted this cycle (only asserted in IDLE)
//   rvalid_o, rdata_o,      response pulse, read data (held until the next
//   err_o                   response), error flag qualified by rvalid_o
//   paddr_o, pwdata_o,      APB master outputs; paddr_o is word aligned,
//   pwrite_o, pstrb_o,      pstrb_o is be_i on writes and 0 on reads
//   psel_o, penable_o
//   prdata_i, pready_i,     APB slave response, sampled only in ACCESS
//   pslverr_i
module apb_master_bridge #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [3:0]                be_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  output logic                      pwrite_o,
  output logic [3:0]                pstrb_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state, state_next;

  logic accept;    // latch a new request into the APB output registers
  logic complete;  // slave answered in ACCESS
  logic abort;     // ACCESS timed out without an answer
  logic expired;   // timeout reached in the current ACCESS cycle

  // The two address LSBs are intentionally dropped: transfers are word aligned
  // and no misalignment error is raised.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr_i[1:0];

`ifdef APB_TIMEOUT_EN
  logic [8:0] tmo_cnt;

  // Counts ACCESS cycles without pready_i; held at zero outside ACCESS, so it
  // is already clear whenever a new ACCESS phase starts.
  always_ff @(posedge clk_i) begin
    if (rst_i || (state != ACCESS)) begin
      tmo_cnt <= '0;
    end else if (!pready_i) begin
      tmo_cnt <= tmo_cnt + 9'd1;
    end
  end

  // Fires in the TIMEOUT_CYCLES-th ACCESS cycle; pready_i in that same cycle
  // still takes priority in the FSM.
  assign expired = (tmo_cnt == 9'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expired        = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    gnt_o      = 1'b0;
    psel_o     = 1'b0;
    penable_o  = 1'b0;
    rvalid_o   = 1'b0;
    accept     = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          accept     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        psel_o     = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        if (pready_i) begin
          complete   = 1'b1;
          state_next = RESP;
        end else if (expired) begin
          abort      = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        rvalid_o   = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request side: APB outputs are loaded only on acceptance, so they stay
  // stable from SETUP through the last ACCESS cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      paddr_o  <= '0;
      pwdata_o <= '0;
      pwrite_o <= 1'b0;
      pstrb_o  <= 4'h0;
    end else if (accept) begin
      paddr_o  <= {addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
      pwdata_o <= wdata_i;
      pwrite_o <= we_i;
      pstrb_o  <= we_i ? be_i : 4'h0;
    end
  end

  // Response side: rdata_o/err_o are held until the next response is captured.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_o <= '0;
      err_o   <= 1'b0;
    end else if (complete) begin
      rdata_o <= pwrite_o ? '0 : prdata_i;
      err_o   <= pslverr_i;
    end else if (abort) begin
      rdata_o <= APB_DATA_WIDTH'(32'hDEAD_BEEF);
      err_o   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
//   Self-checking bench for apb_master_bridge. The bench plays the core and the
//   APB slave. Expected values come from the transfer rules: word-aligned
//   address, strobes only on writes, read data zero on writes, response after
//   SETUP + (waits+1) ACCESS cycles. Works with and without APB_TIMEOUT_EN.
module tb_apb_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          req_i;
  logic [AW-1:0] addr_i;
  logic          we_i;
  logic [3:0]    be_i;
  logic [DW-1:0] wdata_i;
  logic          gnt_o;
  logic          rvalid_o;
  logic [DW-1:0] rdata_o;
  logic          err_o;
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o;
  logic          pwrite_o;
  logic [3:0]    pstrb_o;
  logic          psel_o;
  logic          penable_o;
  logic [DW-1:0] prdata_i;
  logic          pready_i;
  logic          pslverr_i;

  always #5 clk = ~clk;

  apb_master_bridge #(
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .addr_i   (addr_i),
    .we_i     (we_i),
    .be_i     (be_i),
    .wdata_i  (wdata_i),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .paddr_o  (paddr_o),
    .pwdata_o (pwdata_o),
    .pwrite_o (pwrite_o),
    .pstrb_o  (pstrb_o),
    .psel_o   (psel_o),
    .penable_o(penable_o),
    .prdata_i (prdata_i),
    .pready_i (pready_i),
    .pslverr_i(pslverr_i)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_rdata = 32'h0;

`ifdef APB_TIMEOUT_EN
  localparam int MAXW = TO - 1;
`else
  localparam int MAXW = 20;
`endif

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Core side while a transfer is in flight: 0=req low, 1=random, 2=held high.
  task automatic core_junk(input int mode);
    req_i   = (mode == 2) ? 1'b1 : (mode == 1) ? 1'($urandom) : 1'b0;
    addr_i  = $urandom;
    we_i    = 1'($urandom);
    be_i    = 4'($urandom);
    wdata_i = $urandom;
  endtask

  task automatic slave_junk();
    pready_i  = 1'($urandom);
    pslverr_i = 1'($urandom);
    prdata_i  = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      core_junk(0);
      slave_junk();
      #1;
      chk1("idle_gnt", gnt_o, 1'b0);
      chk1("idle_psel", psel_o, 1'b0);
      chk1("idle_rvalid", rvalid_o, 1'b0);
      tick();
    end
  endtask

  // One complete transfer starting in IDLE; the slave answers after 'waits'
  // wait states. Returns with the DUT back in IDLE.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] b,
                      input logic [31:0] wd, input logic [31:0] rd,
                      input logic se, input int waits, input int busy);
    logic [31:0] exp_addr;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_strb;
    exp_addr  = a & 32'hFFFF_FFFC;
    exp_strb  = w ? b : 4'h0;
    exp_rdata = w ? 32'h0 : rd;

    req_i = 1'b1; addr_i = a; we_i = w; be_i = b; wdata_i = wd;
    slave_junk();
    #1;
    chk1("gnt_idle", gnt_o, 1'b1);
    chk1("psel_idle", psel_o, 1'b0);
    chk1("rvalid_idle", rvalid_o, 1'b0);
    chk32("rdata_held", rdata_o, last_rdata);
    tick();

    core_junk(busy);
    slave_junk();
    #1;
    chk1("gnt_setup", gnt_o, 1'b0);
    chk1("psel_setup", psel_o, 1'b1);
    chk1("penable_setup", penable_o, 1'b0);
    chk32("paddr_setup", paddr_o, exp_addr);
    chk1("pwrite_setup", pwrite_o, w);
    chk32("pstrb_setup", {28'h0, pstrb_o}, {28'h0, exp_strb});
    chk32("pwdata_setup", pwdata_o, wd);
    tick();

    for (int k = 0; k <= waits; k++) begin
      core_junk(busy);
      pready_i  = (k == waits);
      pslverr_i = (k == waits) ? se : 1'($urandom);
      prdata_i  = (k == waits) ? rd : $urandom;
      #1;
      chk1("gnt_access", gnt_o, 1'b0);
      chk1("psel_access", psel_o, 1'b1);
      chk1("penable_access", penable_o, 1'b1);
      chk32("paddr_access", paddr_o, exp_addr);
      chk32("pwdata_access", pwdata_o, wd);
      chk32("pstrb_access", {28'h0, pstrb_o}, {28'h0, exp_strb});
      chk1("pwrite_access", pwrite_o, w);
      chk1("rvalid_access", rvalid_o, 1'b0);
      tick();
    end

    core_junk(busy);
    slave_junk();
    #1;
    chk1("rvalid_resp", rvalid_o, 1'b1);
    chk32("rdata_resp", rdata_o, exp_rdata);
    chk1("err_resp", err_o, se);
    chk1("psel_resp", psel_o, 1'b0);
    chk1("penable_resp", penable_o, 1'b0);
    chk1("gnt_resp", gnt_o, 1'b0);
    last_rdata = exp_rdata;
    tick();
  endtask

  int  acc;
  bit  seen;

  initial begin
    rst_i = 1'b1;
    req_i = 1'b0; addr_i = '0; we_i = 1'b0; be_i = 4'h0; wdata_i = '0;
    prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
    tick();
    tick();
    #1;
    chk1("rst_psel", psel_o, 1'b0);
    chk1("rst_penable", penable_o, 1'b0);
    chk1("rst_rvalid", rvalid_o, 1'b0);
    chk1("rst_err", err_o, 1'b0);
    chk1("rst_gnt", gnt_o, 1'b0);
    chk32("rst_rdata", rdata_o, 32'h0);
    chk32("rst_paddr", paddr_o, 32'h0);
    chk32("rst_pwdata", pwdata_o, 32'h0);
    chk32("rst_pstrb", {28'h0, pstrb_o}, 32'h0);
    chk1("rst_pwrite", pwrite_o, 1'b0);
    rst_i = 1'b0;
    tick();

    // Zero-wait read, then write with three wait states, then slave error.
    xfer(32'h1A10_0004, 1'b0, 4'hF, 32'h0, 32'h1234_5678, 1'b0, 0, 0);
    xfer(32'h1A10_1003, 1'b1, 4'h3, 32'hCAFE_F00D, $urandom, 1'b0, 3, 1);
    xfer(32'h1A10_2008, 1'b0, 4'hF, 32'h0, 32'h5A5A_A5A5, 1'b1, 2, 0);

    // Back-to-back reads with the request held high throughout.
    xfer(32'h1A10_0010, 1'b0, 4'hF, 32'h0, 32'h0BAD_F00D, 1'b0, 1, 2);
    xfer(32'h1A10_0014, 1'b0, 4'hF, 32'h0, 32'h7777_8888, 1'b0, 0, 2);
    idle(2);

    // Reset while stalled in ACCESS.
    req_i = 1'b1; addr_i = 32'h1A10_3000; we_i = 1'b1; be_i = 4'hF; wdata_i = 32'h1111_2222;
    pready_i = 1'b0;
    #1;
    chk1("rstx_gnt", gnt_o, 1'b1);
    tick();
    req_i = 1'b0;
    tick();
    pready_i = 1'b0;
    #1;
    chk1("rstx_penable_before", penable_o, 1'b1);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    pready_i = 1'b0;
    #1;
    chk1("rstx_psel", psel_o, 1'b0);
    chk1("rstx_penable", penable_o, 1'b0);
    chk1("rstx_rvalid", rvalid_o, 1'b0);
    chk32("rstx_rdata", rdata_o, 32'h0);
    chk32("rstx_paddr", paddr_o, 32'h0);
    last_rdata = 32'h0;
    tick();
    idle(3);
    xfer(32'h1A10_3004, 1'b0, 4'hF, 32'h0, 32'hFEED_FACE, 1'b0, 1, 0);

`ifdef APB_TIMEOUT_EN
    // pready_i in the expiry cycle completes normally.
    xfer(32'h1A10_4000, 1'b0, 4'hF, 32'h0, 32'h4242_4242, 1'b0, TO - 1, 0);
`endif

    // Slave never answers.
    req_i = 1'b1; addr_i = 32'h1A10_5000; we_i = 1'b0; be_i = 4'hF; wdata_i = '0;
    pready_i = 1'b0;
    #1;
    chk1("tmo_gnt", gnt_o, 1'b1);
    tick();
    req_i = 1'b0;
    tick();
    acc  = 0;
    seen = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      if (rvalid_o) begin
        seen = 1'b1;
        break;
      end
      if (psel_o && penable_o) acc++;
      tick();
    end
`ifdef APB_TIMEOUT_EN
    chk1("tmo_rvalid_seen", seen, 1'b1);
    chk32("tmo_access_cycles", 32'(acc), 32'(TO));
    chk1("tmo_err", err_o, 1'b1);
    chk32("tmo_rdata", rdata_o, 32'hDEAD_BEEF);
    last_rdata = 32'hDEAD_BEEF;
    tick();
`else
    chk1("hang_rvalid_seen", seen, 1'b0);
    chk1("hang_psel", psel_o, 1'b1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    last_rdata = 32'h0;
    #1;
    chk1("hang_rst_psel", psel_o, 1'b0);
    tick();
`endif

    // Randomized transfers against the rule-based expectations.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] ra;
      logic        rw;
      logic [3:0]  rb;
      logic [31:0] rwd;
      logic [31:0] rrd;
      logic        rse;
      ra  = $urandom;
      rw  = 1'($urandom);
      rb  = 4'($urandom);
      rwd = $urandom;
      rrd = $urandom;
      rse = 1'($urandom);
      xfer(ra, rw, rb, rwd, rrd, rse, int'($urandom_range(0, MAXW)), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
